// File: rtl/usb_pkg.sv
// Shared types and PID constants for the host-side USB transaction sequencer.
package usb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TOKEN,
        ST_OUT_DATA,
        ST_OUT_HS,
        ST_IN_DATA,
        ST_IN_HS,
        ST_DONE,
        ST_ERR
    } txn_state_t;

    localparam logic [7:0] PID_OUT = 8'hE1;
    localparam logic [7:0] PID_IN  = 8'h69;
    localparam logic [7:0] PID_ACK = 8'hD2;
    localparam logic [7:0] PID_NAK = 8'h5A;

    // Only an exact ACK counts as success; NAK, STALL and corrupted PIDs all retry.
    function automatic logic is_ack(input logic [7:0] pid);
        return pid == PID_ACK;
    endfunction

endpackage

// File: rtl/usb_txn_timer.sv
// Saturating cycle counter used to bound the wait for a device handshake.
// done is high while the count equals LIMIT.
module usb_txn_timer #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst_L,
    input  logic clear,
    input  logic enable,
    output logic done
);

    localparam int TW = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);
    localparam logic [TW-1:0] LIMIT_W = TW'(LIMIT);

    logic [TW-1:0] count_q;
    logic [TW-1:0] count_d;

    // Clear wins over counting; counting stops once LIMIT is reached.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != LIMIT_W)) begin
            count_d = count_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done = (count_q == LIMIT_W);

endmodule

// File: rtl/usb_txn_ctrl.sv
// Host-side USB transaction sequencer: token -> data phase -> handshake,
// with bounded retry. All outputs are registered.
module usb_txn_ctrl
    import usb_pkg::*;
#(
    parameter int MAX_TRIES  = 8,
    parameter int HS_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst_L,
    input  logic       req_in,
    input  logic       req_out,
    input  logic       tok_done,
    input  logic       txd_done,
    input  logic       hs_tx_done,
    input  logic       rx_success,
    input  logic       rx_fail,
    input  logic       hs_rx_valid,
    input  logic [7:0] hs_rx_pid,
    output logic       tok_start,
    output logic [7:0] tok_pid,
    output logic       txd_start,
    output logic       r_data_start,
    output logic       hs_tx_start,
    output logic [7:0] hs_tx_pid,
    output logic       hs_listen,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [3:0] tries
);

    localparam logic [4:0] MAX_TRIES_W = 5'(MAX_TRIES);

    txn_state_t state_q, state_d;
    logic       first_q, first_d;
    logic       dir_in_q, dir_in_d;
    logic [7:0] tok_pid_q, tok_pid_d;
    logic [7:0] hs_tx_pid_q, hs_tx_pid_d;
    logic [3:0] tries_q, tries_d;
    logic       tok_start_q, tok_start_d;
    logic       txd_start_q, txd_start_d;
    logic       r_data_start_q, r_data_start_d;
    logic       hs_tx_start_q, hs_tx_start_d;
    logic       hs_listen_q, hs_listen_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       error_q, error_d;
    logic       retry;
    logic       hs_timer_clear;
    logic       hs_timer_done;

    // Handshake timer: restarts from zero on the first OUT_HS cycle, counts while listening.
    usb_txn_timer #(
        .LIMIT(HS_TIMEOUT)
    ) u_hs_timer (
        .clk   (clk),
        .rst_L (rst_L),
        .clear (hs_timer_clear),
        .enable(state_q == ST_OUT_HS),
        .done  (hs_timer_done)
    );

    assign hs_timer_clear = (state_d == ST_OUT_HS) && (state_q != ST_OUT_HS);

    // Next-state, retry bookkeeping and the registered start/status pulses.
    always_comb begin
        state_d     = state_q;
        dir_in_d    = dir_in_q;
        tok_pid_d   = tok_pid_q;
        hs_tx_pid_d = hs_tx_pid_q;
        tries_d     = tries_q;
        retry       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_in) begin
                    dir_in_d  = 1'b1;
                    tok_pid_d = PID_IN;
                    tries_d   = '0;
                    state_d   = ST_TOKEN;
                end else if (req_out) begin
                    dir_in_d  = 1'b0;
                    tok_pid_d = PID_OUT;
                    tries_d   = '0;
                    state_d   = ST_TOKEN;
                end
            end
            ST_TOKEN: begin
                if (!first_q && tok_done) begin
                    state_d = dir_in_q ? ST_IN_DATA : ST_OUT_DATA;
                end
            end
            ST_IN_DATA: begin
                if (!first_q) begin
                    if (rx_fail) begin
                        hs_tx_pid_d = PID_NAK;
                        state_d     = ST_IN_HS;
                    end else if (rx_success) begin
                        hs_tx_pid_d = PID_ACK;
                        state_d     = ST_IN_HS;
                    end
                end
            end
            ST_IN_HS: begin
                if (!first_q && hs_tx_done) begin
                    if (is_ack(hs_tx_pid_q)) begin
                        state_d = ST_DONE;
                    end else begin
                        retry = 1'b1;
                    end
                    hs_tx_pid_d = 8'h00;
                end
            end
            ST_OUT_DATA: begin
                if (!first_q && txd_done) begin
                    state_d = ST_OUT_HS;
                end
            end
            ST_OUT_HS: begin
                if (hs_rx_valid) begin
                    if (is_ack(hs_rx_pid)) begin
                        state_d = ST_DONE;
                    end else begin
                        retry = 1'b1;
                    end
                end else if (hs_timer_done) begin
                    retry = 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (retry) begin
            if (tries_q != 4'hF) begin
                tries_d = tries_q + 4'd1;
            end
            state_d = (({1'b0, tries_q} + 5'd1) == MAX_TRIES_W) ? ST_ERR : ST_TOKEN;
        end

        first_d        = (state_d != state_q);
        tok_start_d    = (state_d == ST_TOKEN)    && (state_q != ST_TOKEN);
        txd_start_d    = (state_d == ST_OUT_DATA) && (state_q != ST_OUT_DATA);
        r_data_start_d = (state_d == ST_IN_DATA)  && (state_q != ST_IN_DATA);
        hs_tx_start_d  = (state_d == ST_IN_HS)    && (state_q != ST_IN_HS);
        hs_listen_d    = (state_d == ST_OUT_HS);
        busy_d         = (state_d != ST_IDLE);
        done_d         = (state_d == ST_DONE);
        error_d        = (state_d == ST_ERR);
    end

    // State, counters and output registers; reset aborts any transaction silently.
    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            state_q        <= ST_IDLE;
            first_q        <= 1'b0;
            dir_in_q       <= 1'b0;
            tok_pid_q      <= 8'h00;
            hs_tx_pid_q    <= 8'h00;
            tries_q        <= '0;
            tok_start_q    <= 1'b0;
            txd_start_q    <= 1'b0;
            r_data_start_q <= 1'b0;
            hs_tx_start_q  <= 1'b0;
            hs_listen_q    <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            first_q        <= first_d;
            dir_in_q       <= dir_in_d;
            tok_pid_q      <= tok_pid_d;
            hs_tx_pid_q    <= hs_tx_pid_d;
            tries_q        <= tries_d;
            tok_start_q    <= tok_start_d;
            txd_start_q    <= txd_start_d;
            r_data_start_q <= r_data_start_d;
            hs_tx_start_q  <= hs_tx_start_d;
            hs_listen_q    <= hs_listen_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            error_q        <= error_d;
        end
    end

    assign tok_start    = tok_start_q;
    assign tok_pid      = tok_pid_q;
    assign txd_start    = txd_start_q;
    assign r_data_start = r_data_start_q;
    assign hs_tx_start  = hs_tx_start_q;
    assign hs_tx_pid    = hs_tx_pid_q;
    assign hs_listen    = hs_listen_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = error_q;
    assign tries        = tries_q;

endmodule

// File: tb/tb_usb_txn_ctrl.sv
// Directed testbench for usb_txn_ctrl: the bench plays the tx engines,
// receive_data FSM and device handshake, and checks against hand-computed values.
module tb_usb_txn_ctrl;

    localparam int HS_TIMEOUT = 255;

    logic       clock = 1'b0;
    logic       rstL = 1'b0;
    logic       reqIn = 1'b0;
    logic       reqOut = 1'b0;
    logic       tokDone = 1'b0;
    logic       txdDone = 1'b0;
    logic       hsTxDone = 1'b0;
    logic       rxSuccess = 1'b0;
    logic       rxFail = 1'b0;
    logic       hsRxValid = 1'b0;
    logic [7:0] hsRxPid = 8'h00;

    logic       tokStart, txdStart, rDataStart, hsTxStart, hsListen;
    logic       busy, done, error;
    logic [7:0] tokPid, hsTxPid;
    logic [3:0] tries;

    int checkCount = 0;
    int errorCount = 0;

    // Event counters sampled on the rising edge, read by the stimulus on the falling edge.
    int tokCount = 0, txdCount = 0, rdCount = 0, nakCount = 0, ackCount = 0;
    int doneCount = 0, errCount = 0, listenCount = 0;
    int tokBase, txdBase, rdBase, nakBase, ackBase, doneBase, errBase, listenBase;

    usb_txn_ctrl #(
        .MAX_TRIES (8),
        .HS_TIMEOUT(HS_TIMEOUT)
    ) dut (
        .clk         (clock),
        .rst_L       (rstL),
        .req_in      (reqIn),
        .req_out     (reqOut),
        .tok_done    (tokDone),
        .txd_done    (txdDone),
        .hs_tx_done  (hsTxDone),
        .rx_success  (rxSuccess),
        .rx_fail     (rxFail),
        .hs_rx_valid (hsRxValid),
        .hs_rx_pid   (hsRxPid),
        .tok_start   (tokStart),
        .tok_pid     (tokPid),
        .txd_start   (txdStart),
        .r_data_start(rDataStart),
        .hs_tx_start (hsTxStart),
        .hs_tx_pid   (hsTxPid),
        .hs_listen   (hsListen),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .tries       (tries)
    );

    // 10 time-unit clock.
    always #5 clock = ~clock;

    // Watchdog so a stuck design can never hang the run.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    // Count each output pulse once per cycle it is high.
    always @(posedge clock) begin
        if (tokStart)                         tokCount    <= tokCount + 1;
        if (txdStart)                         txdCount    <= txdCount + 1;
        if (rDataStart)                       rdCount     <= rdCount + 1;
        if (hsTxStart && hsTxPid == 8'h5A)    nakCount    <= nakCount + 1;
        if (hsTxStart && hsTxPid == 8'hD2)    ackCount    <= ackCount + 1;
        if (done)                             doneCount   <= doneCount + 1;
        if (error)                            errCount    <= errCount + 1;
        if (hsListen)                         listenCount <= listenCount + 1;
    end

    // Single comparison point: counts the check and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Snapshot the counters so each scenario checks only its own events.
    task automatic markCounts();
        tokBase = tokCount; txdBase = txdCount; rdBase = rdCount; nakBase = nakCount;
        ackBase = ackCount; doneBase = doneCount; errBase = errCount; listenBase = listenCount;
    endtask

    // Raise the named input(s) for exactly one cycle, starting at the next falling edge.
    task automatic applyStimulus(input string name, input logic [7:0] pid = 8'h00);
        @(negedge clock);
        if (name == "req_in")        reqIn = 1'b1;
        else if (name == "req_out")  reqOut = 1'b1;
        else if (name == "req_both") begin reqIn = 1'b1; reqOut = 1'b1; end
        else if (name == "tok_done") tokDone = 1'b1;
        else if (name == "txd_done") txdDone = 1'b1;
        else if (name == "hs_tx_done") hsTxDone = 1'b1;
        else if (name == "rx_success") rxSuccess = 1'b1;
        else if (name == "rx_fail")  rxFail = 1'b1;
        else if (name == "rx_both")  begin rxFail = 1'b1; rxSuccess = 1'b1; end
        else if (name == "hs_rx")    begin hsRxValid = 1'b1; hsRxPid = pid; end
        @(negedge clock);
        reqIn = 1'b0; reqOut = 1'b0; tokDone = 1'b0; txdDone = 1'b0; hsTxDone = 1'b0;
        rxSuccess = 1'b0; rxFail = 1'b0; hsRxValid = 1'b0; hsRxPid = 8'h00;
    endtask

    function automatic logic outputLevel(input string name);
        if (name == "tok_start")    return tokStart;
        if (name == "txd_start")    return txdStart;
        if (name == "r_data_start") return rDataStart;
        if (name == "hs_tx_start")  return hsTxStart;
        if (name == "done")         return done;
        if (name == "error")        return error;
        return 1'b0;
    endfunction

    // Wait (bounded) until the named output is high at a falling edge; counts as a check.
    task automatic waitFor(input string name, input int budget);
        bit seen = 0;
        for (int i = 0; i < budget; i++) begin
            if (outputLevel(name)) begin
                seen = 1;
                break;
            end
            @(negedge clock);
        end
        checkOutput({"wait_", name}, 32'(seen), 32'd1);
    endtask

    // One IN attempt: token, receive data (good, bad or both), handshake send.
    task automatic runInAttempt(input string rxEvent, input logic [7:0] expPid, input int rxDelay);
        waitFor("tok_start", 20);
        applyStimulus("tok_done");
        waitFor("r_data_start", 20);
        repeat (rxDelay) @(negedge clock);
        applyStimulus(rxEvent);
        waitFor("hs_tx_start", 20);
        checkOutput("hs_tx_pid", 32'(hsTxPid), 32'(expPid));
        applyStimulus("hs_tx_done");
    endtask

    initial begin
        // Reset state.
        repeat (3) @(negedge clock);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_tok_pid", 32'(tokPid), 0);
        checkOutput("rst_hs_tx_pid", 32'(hsTxPid), 0);
        checkOutput("rst_tries", 32'(tries), 0);
        checkOutput("rst_pulses", 32'({tokStart, txdStart, rDataStart, hsTxStart, hsListen, done, error}), 0);
        rstL = 1'b1;
        repeat (2) @(negedge clock);

        // IN transaction, success 40 cycles after r_data_start.
        markCounts();
        applyStimulus("req_in");
        checkOutput("in1_tok_start_latency", 32'(tokStart), 1);
        checkOutput("in1_tok_pid", 32'(tokPid), 32'h69);
        checkOutput("in1_busy", 32'(busy), 1);
        runInAttempt("rx_success", 8'hD2, 39);
        checkOutput("in1_done_latency", 32'(done), 1);
        checkOutput("in1_tries", 32'(tries), 0);
        @(negedge clock);
        checkOutput("in1_idle", 32'(busy), 0);
        checkOutput("in1_tok_count", 32'(tokCount - tokBase), 1);
        checkOutput("in1_done_count", 32'(doneCount - doneBase), 1);

        // IN: three failures (the first with fail and success together) then success.
        markCounts();
        applyStimulus("req_in");
        runInAttempt("rx_both", 8'h5A, 3);
        runInAttempt("rx_fail", 8'h5A, 0);
        runInAttempt("rx_fail", 8'h5A, 5);
        runInAttempt("rx_success", 8'hD2, 1);
        checkOutput("in2_done", 32'(done), 1);
        checkOutput("in2_tries", 32'(tries), 3);
        @(negedge clock);
        checkOutput("in2_tok_count", 32'(tokCount - tokBase), 4);
        checkOutput("in2_nak_count", 32'(nakCount - nakBase), 3);
        checkOutput("in2_ack_count", 32'(ackCount - ackBase), 1);

        // IN: eight failures exhaust the retry budget.
        markCounts();
        applyStimulus("req_in");
        for (int a = 0; a < 8; a++) runInAttempt("rx_fail", 8'h5A, 1);
        checkOutput("in3_error", 32'(error), 1);
        checkOutput("in3_tries", 32'(tries), 8);
        @(negedge clock);
        checkOutput("in3_idle", 32'(busy), 0);
        checkOutput("in3_tries_held", 32'(tries), 8);
        checkOutput("in3_nak_count", 32'(nakCount - nakBase), 8);
        checkOutput("in3_done_count", 32'(doneCount - doneBase), 0);
        checkOutput("in3_err_count", 32'(errCount - errBase), 1);

        // OUT: device NAKs, then ACKs; a request while busy is ignored.
        markCounts();
        applyStimulus("req_out");
        checkOutput("out1_tok_pid", 32'(tokPid), 32'hE1);
        applyStimulus("tok_done");
        waitFor("txd_start", 20);
        checkOutput("out1_no_listen_in_data", 32'(hsListen), 0);
        applyStimulus("req_in");
        checkOutput("out1_busy_req_ignored", 32'(tokPid), 32'hE1);
        applyStimulus("txd_done");
        checkOutput("out1_listen", 32'(hsListen), 1);
        applyStimulus("hs_rx", 8'h5A);
        waitFor("tok_start", 2);
        applyStimulus("tok_done");
        waitFor("txd_start", 20);
        applyStimulus("txd_done");
        applyStimulus("hs_rx", 8'hD2);
        checkOutput("out1_done", 32'(done), 1);
        checkOutput("out1_tries", 32'(tries), 1);
        @(negedge clock);
        checkOutput("out1_txd_count", 32'(txdCount - txdBase), 2);
        checkOutput("out1_listen_cycles", 32'(listenCount - listenBase), 4);

        // OUT: handshake timeout, then an ACK arriving exactly in the timeout cycle.
        markCounts();
        applyStimulus("req_out");
        applyStimulus("tok_done");
        waitFor("txd_start", 20);
        applyStimulus("txd_done");
        repeat (HS_TIMEOUT) @(negedge clock);
        checkOutput("out2_still_listening", 32'(hsListen), 1);
        checkOutput("out2_no_early_retry", 32'(tokStart), 0);
        @(negedge clock);
        checkOutput("out2_timeout_retry", 32'(tokStart), 1);
        checkOutput("out2_tries", 32'(tries), 1);
        applyStimulus("tok_done");
        waitFor("txd_start", 20);
        applyStimulus("txd_done");
        repeat (HS_TIMEOUT - 1) @(negedge clock);
        applyStimulus("hs_rx", 8'hD2);
        checkOutput("out2_ack_at_timeout", 32'(done), 1);
        checkOutput("out2_tries_final", 32'(tries), 1);
        @(negedge clock);
        checkOutput("out2_listen_cycles", 32'(listenCount - listenBase), 2 * (HS_TIMEOUT + 1));

        // Both requests together: IN wins. Then reset aborts an OUT in its data phase.
        markCounts();
        applyStimulus("req_both");
        checkOutput("both_tok_pid", 32'(tokPid), 32'h69);
        rstL = 1'b0;
        @(negedge clock);
        rstL = 1'b1;
        applyStimulus("req_out");
        applyStimulus("tok_done");
        waitFor("txd_start", 20);
        @(negedge clock);
        rstL = 1'b0;
        #1;
        checkOutput("abort_busy", 32'(busy), 0);
        checkOutput("abort_tok_pid", 32'(tokPid), 0);
        checkOutput("abort_tries", 32'(tries), 0);
        @(negedge clock);
        rstL = 1'b1;
        repeat (5) @(negedge clock);
        checkOutput("abort_still_idle", 32'(busy), 0);
        checkOutput("abort_no_done", 32'(doneCount - doneBase), 0);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
